// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one request/ack read per instruction from the PC register,
// delivered to IF/ID with a valid flag; drives the PC hold so the PC advances once per delivery or flush.
module if_fetch_unit #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        id_stall_i,
    output logic        pc_hold_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_FETCH,
        S_OUT,
        S_ERR
    } state_e;

    state_e           state_q;
    logic             kill_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      instr_q;
    logic [31:0]      instr_pc_q;
    logic             instr_valid_q;
    logic             misalign_q;
    logic             timeout_q;

    // Handshakes: memory side holds mem_req_o with a stable address until a single-cycle
    // mem_ack_i; IF/ID side transfers on any cycle with instr_valid_o=1 and id_stall_i=0.
    always_comb begin
        pc_hold_o = 1'b1;
        if ((state_q == S_ISSUE || state_q == S_FETCH || state_q == S_OUT) && flush_i) begin
            pc_hold_o = 1'b0;
        end
        if (state_q == S_OUT && !id_stall_i) begin
            pc_hold_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            kill_q        <= 1'b0;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A flush here means the PC loads the redirect target on this edge.
                    if (flush_i) begin
                        state_q <= S_ISSUE;
                    end else if (!start_i) begin
                        state_q <= S_IDLE;
                    end else if (pc_i[1:0] != 2'b00) begin
                        misalign_q <= 1'b1;
                        state_q    <= S_ERR;
                    end else begin
                        mem_addr_q <= pc_i;
                        mem_req_q  <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        if (kill_q || flush_i) begin
                            kill_q  <= 1'b0;
                            state_q <= S_ISSUE;
                        end else begin
                            instr_q       <= mem_rdata_i;
                            instr_pc_q    <= mem_addr_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_OUT;
                        end
                    end else begin
                        if (flush_i) begin
                            kill_q <= 1'b1;
                        end
                        if (cnt_q == CNT_LAST) begin
                            timeout_q <= 1'b1;
                            mem_req_q <= 1'b0;
                            state_q   <= S_ERR;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (flush_i) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_ISSUE;
                    end else if (!id_stall_i) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= start_i ? S_ISSUE : S_IDLE;
                    end
                end
                default: begin
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    state_q       <= S_ERR;
                end
            endcase
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;
    assign misalign_o    = misalign_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: acts as PC register, instruction memory and ID stage; a monitor
// checks every IF/ID transfer against the architectural PC stream kept in exp_q.
module tb_if_fetch_unit;

    localparam int TIMEOUT_CYC = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        id_stall_i;
    logic        pc_hold_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        misalign_o;
    logic        timeout_o;

    logic [63:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          delivered = 0;
    int          hold_low_cnt = 0;
    logic [31:0] flush_tgt = 32'h0;
    bit          mem_en = 1'b1;
    bit          mem_busy = 1'b0;
    bit          inject_ack = 1'b0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    int          wait_cnt = -1;

    if_fetch_unit #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .id_stall_i   (id_stall_i),
        .pc_hold_o    (pc_hold_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_valid_o(instr_valid_o),
        .misalign_o   (misalign_o),
        .timeout_o    (timeout_o)
    );

    // Clock and watchdog
    initial forever #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic sig_of(input int which);
        case (which)
            0:       return mem_req_o;
            1:       return instr_valid_o;
            default: return mem_ack_i;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample the PC hold at the negedge, then after the edge act as the PC
    // register (load target on flush, else +4) and as the variable-latency memory.
    task automatic cycle();
        logic hold_s;
        logic flush_s;
        @(negedge clk_i);
        hold_s  = pc_hold_o;
        flush_s = flush_i;
        @(posedge clk_i);
        #1;
        if (!hold_s) begin
            hold_low_cnt++;
            if (flush_s) begin
                pc_i = flush_tgt;
                exp_q.delete();
            end else begin
                pc_i = pc_i + 32'd4;
            end
            exp_q.push_back({pc_i, mem_word(pc_i)});
        end
        flush_i   = 1'b0;
        mem_ack_i = 1'b0;
        if (!mem_req_o) begin
            mem_busy = 1'b0;
        end else if (!mem_busy) begin
            mem_busy = 1'b1;
            wait_cnt = $urandom_range(lat_hi, lat_lo);
        end
        if (inject_ack) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = $urandom();
            inject_ack  = 1'b0;
        end else if (mem_busy && mem_en) begin
            if (wait_cnt == 0) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_word(mem_addr_o);
            end
            wait_cnt--;
        end
    endtask

    task automatic wait_sig(input int which, input string name);
        int n = 0;
        while (!sig_of(which) && n < 100) begin
            cycle();
            n++;
        end
        check(name, sig_of(which), 1'b1);
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst_i      = 1'b0;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        id_stall_i = 1'b0;
        pc_i       = pc0;
        mem_ack_i  = 1'b0;
        mem_busy   = 1'b0;
        inject_ack = 1'b0;
        exp_q.delete();
        exp_q.push_back({pc0, mem_word(pc0)});
        repeat (2) cycle();
        check("reset_ctrl", {mem_req_o, instr_valid_o, misalign_o, timeout_o, pc_hold_o}, 5'b00001);
        check("reset_data", {mem_addr_o, instr_o}, 64'h0);
        check("reset_ipc", instr_pc_o, 32'h0);
        rst_i = 1'b1;
    endtask

    // Scoreboard monitor: every transfer must be the instruction at the current PC
    always @(negedge clk_i) begin
        logic [63:0] exp_e;
        if (rst_i) begin
            if (instr_valid_o && !id_stall_i && !flush_i) begin
                check("hold_on_accept", pc_hold_o, 1'b0);
                check("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    check("sb_instr", {instr_pc_o, instr_o}, exp_e);
                    delivered++;
                end
            end else if (!pc_hold_o) begin
                check("hold_cause", flush_i, 1'b1);
            end
        end
    end

    initial begin
        int n;
        int h0;
        int d0;
        bit saw_req;
        mem_rdata_i = 32'h0;

        // Basic fetch at 0x0 with ack two cycles after request
        do_reset(32'h0);
        lat_lo = 2; lat_hi = 2;
        start_i = 1'b1;
        wait_sig(0, "t1_req");
        check("t1_addr", mem_addr_o, 32'h0);
        hold_low_cnt = 0;
        n = 0;
        while (!mem_ack_i && n < 20) begin
            cycle();
            n++;
        end
        check("t1_ack_lat", n, 2);
        check("t1_valid_at_ack", instr_valid_o, 1'b0);
        start_i = 1'b0;
        cycle();
        check("t1_valid", instr_valid_o, 1'b1);
        check("t1_instr", instr_o, 32'h0050_0093);
        check("t1_ipc", instr_pc_o, 32'h0);
        cycle();
        check("t1_valid_drop", instr_valid_o, 1'b0);
        repeat (2) cycle();
        check("t1_hold_pulses", hold_low_cnt, 1);

        // ID stall holds the instruction and the PC
        lat_lo = 1; lat_hi = 1;
        id_stall_i = 1'b1;
        start_i = 1'b1;
        wait_sig(1, "t2_valid");
        check("t2_ipc", instr_pc_o, 32'h4);
        h0 = hold_low_cnt;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_stall_valid", instr_valid_o, 1'b1);
            check("t2_stall_instr", instr_o, mem_word(32'h4));
        end
        check("t2_stall_hold", hold_low_cnt, h0);
        id_stall_i = 1'b0;
        start_i = 1'b0;
        cycle();
        check("t2_accept", instr_valid_o, 1'b0);

        // Flush mid-FETCH: the returning word is wrong-path
        lat_lo = 3; lat_hi = 3;
        start_i = 1'b1;
        wait_sig(0, "t3_req");
        check("t3_addr", mem_addr_o, 32'h8);
        cycle();
        flush_i = 1'b1;
        flush_tgt = 32'h40;
        cycle();
        wait_sig(2, "t3_ack");
        cycle();
        check("t3_discard", instr_valid_o, 1'b0);
        wait_sig(0, "t3_req2");
        check("t3_redirect", mem_addr_o, 32'h40);
        wait_sig(1, "t3_valid");
        check("t3_ipc", instr_pc_o, 32'h40);
        cycle();

        // Flush and accept in the same OUT cycle: flush wins
        id_stall_i = 1'b1;
        wait_sig(1, "t4_valid");
        check("t4_ipc", instr_pc_o, 32'h44);
        id_stall_i = 1'b0;
        flush_i = 1'b1;
        flush_tgt = 32'h80;
        h0 = hold_low_cnt;
        cycle();
        check("t4_drop", instr_valid_o, 1'b0);
        check("t4_one_pc_step", hold_low_cnt, h0 + 1);
        wait_sig(0, "t4_req");
        check("t4_redirect", mem_addr_o, 32'h80);
        wait_sig(1, "t4_valid2");
        check("t4_instr", {instr_pc_o, instr_o}, {32'h80, mem_word(32'h80)});
        cycle();

        // Random traffic: stalls, flushes, start toggling, variable latency
        lat_lo = 0; lat_hi = 5;
        d0 = delivered;
        for (int i = 0; i < 400; i++) begin
            start_i    = ($urandom_range(0, 19) != 0);
            id_stall_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) begin
                flush_i   = 1'b1;
                flush_tgt = 32'($urandom_range(0, 1023)) << 2;
            end
            cycle();
        end
        start_i = 1'b0;
        id_stall_i = 1'b0;
        repeat (20) cycle();
        check("rand_idle", {mem_req_o, instr_valid_o}, 2'b00);
        check("rand_progress", (delivered - d0) > 20, 1'b1);
        check("rand_sb_depth", exp_q.size(), 1);

        // Misaligned PC goes to ERR without a request
        do_reset(32'h6);
        start_i = 1'b1;
        saw_req = 1'b0;
        repeat (6) begin
            cycle();
            if (mem_req_o) saw_req = 1'b1;
        end
        check("t5_misalign", misalign_o, 1'b1);
        check("t5_no_req", saw_req, 1'b0);
        check("t5_no_timeout", timeout_o, 1'b0);

        // No ack: timeout exactly TIMEOUT_CYC cycles after request rises
        do_reset(32'h100);
        mem_en = 1'b0;
        start_i = 1'b1;
        wait_sig(0, "t5_req");
        n = 0;
        while (!timeout_o && n < 200) begin
            cycle();
            n++;
        end
        check("t5_timeout_cyc", n, TIMEOUT_CYC);
        check("t5_err_outs", {mem_req_o, instr_valid_o, misalign_o}, 3'b000);
        h0 = hold_low_cnt;
        flush_i = 1'b1;
        flush_tgt = 32'h0;
        repeat (4) cycle();
        check("t5_err_hold", hold_low_cnt, h0);
        check("t5_err_req", mem_req_o, 1'b0);
        mem_en = 1'b1;

        // Reset while requesting, then a stray ack after release
        do_reset(32'h200);
        lat_lo = 4; lat_hi = 4;
        start_i = 1'b1;
        wait_sig(0, "t6_req");
        cycle();
        rst_i = 1'b0;
        #1;
        check("t6_async_req", mem_req_o, 1'b0);
        check("t6_async_addr", mem_addr_o, 32'h0);
        start_i = 1'b0;
        cycle();
        rst_i = 1'b1;
        inject_ack = 1'b1;
        repeat (2) cycle();
        check("t6_after_ack", {mem_req_o, instr_valid_o, misalign_o, timeout_o}, 4'b0000);
        check("t6_after_data", {instr_pc_o, instr_o}, 64'h0);
        lat_lo = 1; lat_hi = 1;
        start_i = 1'b1;
        wait_sig(1, "t6_valid");
        check("t6_instr", {instr_pc_o, instr_o}, {32'h200, mem_word(32'h200)});
        start_i = 1'b0;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
